// File: rtl/zero_detector_pkg.sv
// -----------------------------------------------------------------------------
// zero_detector_pkg
// Shared state encoding for the zero_detector FSM.
// The 2'b11 encoding is deliberately left unnamed: it is illegal and the FSM
// recovers from it to S_IDLE.
// -----------------------------------------------------------------------------
package zero_detector_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE  = 2'b00,   // no pending zero
      S_ZERO1 = 2'b01,   // exactly one zero seen
      S_ZERO2 = 2'b10    // two or more consecutive zeros seen
   } state_t;

endpackage : zero_detector_pkg

// File: rtl/zero_detector.sv
// -----------------------------------------------------------------------------
// zero_detector
// Moore FSM that flags two or more consecutive zero bits on a serial stream.
//
// Ports:
//   clk        : system clock, all state updates on rising edge
//   reset      : synchronous active-high reset, forces S_IDLE
//   i_seq      : serial input bit, sampled every rising edge
//   o_detected : high while in S_ZERO2 (decoded from the state flop only)
//   state      : raw state register value for debug/observation
// -----------------------------------------------------------------------------
module zero_detector
   import zero_detector_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_seq,
   output logic               o_detected,
   output logic [STATE_W-1:0] state
);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_next;

   // State register; reset has priority over every transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; any 1 returns to idle, zeros count up and saturate
   // at S_ZERO2 so longer runs stay detected. 2'b11 falls to the default.
   always_comb begin
      w_next = S_IDLE;
      case (r_state)
         S_IDLE:  w_next = i_seq ? S_IDLE : S_ZERO1;
         S_ZERO1: w_next = i_seq ? S_IDLE : S_ZERO2;
         S_ZERO2: w_next = i_seq ? S_IDLE : S_ZERO2;
         default: w_next = S_IDLE;
      endcase
   end

   // Moore outputs straight from the state flop.
   assign o_detected = (r_state == S_ZERO2);
   assign state      = r_state;

endmodule : zero_detector

// File: tb/tb_zero_detector.sv
// -----------------------------------------------------------------------------
// tb_zero_detector
// Self-checking bench for zero_detector. Each step drives reset/i_seq away
// from the clock edge, predicts the post-edge state with a saturating zero
// counter, queues the prediction, and compares it just after the edge.
// -----------------------------------------------------------------------------
module tb_zero_detector;

   logic       clk;
   logic       reset;
   logic       i_seq;
   logic       o_detected;
   logic [1:0] state;

   typedef struct packed {
      logic [1:0] st;
      logic       det;
   } exp_t;

   exp_t q_exp[$];
   int   zero_cnt;
   int   n_checks;
   int   n_errors;

   zero_detector u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_seq      (i_seq),
      .o_detected (o_detected),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [1:0] obs,
                           input logic [1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus, push the prediction, then check after the edge.
   task automatic step(input string tag, input logic rst, input logic seq);
      exp_t e;
      @(negedge clk);
      reset = rst;
      i_seq = seq;
      if (rst || seq)
         zero_cnt = 0;
      else if (zero_cnt < 2)
         zero_cnt = zero_cnt + 1;
      e.st  = (zero_cnt == 0) ? 2'b00 : (zero_cnt == 1) ? 2'b01 : 2'b10;
      e.det = (zero_cnt >= 2);
      q_exp.push_back(e);
      @(posedge clk);
      #1;
      if (q_exp.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = q_exp.pop_front();
         check_eq({tag, "_state"}, state, e.st);
         check_eq({tag, "_det"}, {1'b0, o_detected}, {1'b0, e.det});
      end
   endtask

   initial begin
      clk      = 1'b0;
      reset    = 1'b1;
      i_seq    = 1'b1;
      zero_cnt = 0;
      n_checks = 0;
      n_errors = 0;

      // Reset check
      step("rst", 1'b1, 1'b1);

      // Single zero: 1,0,1
      step("single0", 1'b0, 1'b1);
      step("single1", 1'b0, 1'b0);
      step("single2", 1'b0, 1'b1);

      // Two zeros: 1,0,0
      step("rst2", 1'b1, 1'b1);
      step("two0", 1'b0, 1'b1);
      step("two1", 1'b0, 1'b0);
      step("two2", 1'b0, 1'b0);

      // Overlap and exit from S_ZERO2: 0,0,1
      step("ovl0", 1'b0, 1'b0);
      step("ovl1", 1'b0, 1'b0);
      step("ovl2", 1'b0, 1'b1);

      // Reset mid-run discards partial count
      step("mid0", 1'b0, 1'b0);
      step("mid_rst", 1'b1, 1'b0);
      step("mid1", 1'b0, 1'b0);

      // Reset priority while in S_ZERO2
      step("pri0", 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step("pri_rst", 1'b1, 1'b0);
      step("pri_rel0", 1'b0, 1'b0);
      step("pri_rel1", 1'b0, 1'b0);

      // Random stream with zero-biased input and sparse resets
      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 2) == 0));
      end

      n_checks++;
      if (q_exp.size() != 0) begin
         n_errors++;
         $display("FAIL sb_drain: %0d entries left, expected 0", q_exp.size());
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_zero_detector

// File: doc/zero_detector.md
Name: zero_detector

Overview:
- Moore finite-state machine that watches a serial bit stream `i_seq`, sampled once per rising clock edge.
- It asserts `o_detected` once two or more consecutive 0 bits have been received.
- It exposes its current state encoding for debug and observation.
- It is a leaf control block used as a serial pattern/idle-line detector; it has no handshake.

Parameters:
- None. Detection length is fixed at two consecutive zeros. State width is fixed at 2 bits.

Ports:
- clk  input  1  Single system clock; all state updates occur on its rising edge.
- reset  input  1  Synchronous, active-high reset; forces the FSM to S_IDLE at the next rising edge of clk.
- i_seq  input  1  Serial input bit, sampled on each rising edge of clk.
- o_detected  output  1  High while the FSM is in S_ZERO2 (two or more consecutive zeros received).
- state  output  2  Current FSM state register value, driven directly from the state flop.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on port reset. All flops update on the rising edge of clk only.
- State encoding:
  - S_IDLE = 2'b00: no pending zero; last sampled bit was 1, or just out of reset.
  - S_ZERO1 = 2'b01: exactly one zero seen.
  - S_ZERO2 = 2'b10: two or more consecutive zeros seen.
  - 2'b11 is illegal.
- Reset:
  - If reset = 1 at a rising edge, then next state = S_IDLE, regardless of i_seq or current state.
  - Reset has priority over all transitions.
  - After reset, state = 2'b00 and o_detected = 0.
  - Reset asserted mid-sequence discards any partial zero count.
- Transitions, evaluated at a rising edge with reset = 0:
  - S_IDLE: i_seq = 0 -> S_ZERO1; i_seq = 1 -> S_IDLE.
  - S_ZERO1: i_seq = 0 -> S_ZERO2; i_seq = 1 -> S_IDLE.
  - S_ZERO2: i_seq = 0 -> S_ZERO2 (overlapping; stays detected for runs of 3 or more zeros); i_seq = 1 -> S_IDLE.
  - 2'b11 -> S_IDLE unconditionally (self-recovery).
- Output:
  - o_detected = (state == S_ZERO2). It is purely Moore and combinational from the state register, with no dependence on the current i_seq.
  - Latency: o_detected rises in the cycle after the edge that samples the second consecutive 0. It falls in the cycle after the edge that samples a 1 or reset.
- state output equals the state register exactly; no extra pipeline stage.
- Before the first reset, the state is undefined. Benches must apply reset before checking.
- Implementation style: one sequential block for the state register, one combinational next-state block with a default assignment to S_IDLE, and one combinational output assignment. No latches.

Decomposition:
- Shared package zero_detector_pkg holds the state localparams/typedef: S_IDLE = 2'b00, S_ZERO1 = 2'b01, S_ZERO2 = 2'b10.
- No sub-module; the block is a single flat FSM.

Test Plan:
- Reset check: hold reset = 1 for 1 edge with i_seq = 1 -> state = 2'b00, o_detected = 0.
- Single zero: after reset, apply i_seq = 1, 0, 1 on successive edges -> state = 00, 01, 00; o_detected stays 0 throughout.
- Two zeros: after reset, apply i_seq = 1, 0, 0 -> state = 00, 01, 10; o_detected = 1 after the third edge.
- Overlap and exit: from S_ZERO2, apply i_seq = 0, 0, 1 -> state = 10, 10, 00; o_detected = 1, 1, 0.
- Reset mid-run: reach S_ZERO1 with one 0, then assert reset with i_seq = 0 -> state = 00. The next 0 gives 01, not 10.
- Reset priority: in S_ZERO2, assert reset = 1 with i_seq = 0 for several edges -> state remains 00 and o_detected = 0 until reset is released.
